// File: rtl/mac_seq_ctrl_if.sv
// Word-addressed read port between the MAC sequencer and the A/b memory.
// The read data itself goes straight to the datapath and is not part of this bundle.
interface mac_seq_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_read;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_waitrequest;
  logic                  mem_readdatavalid;

  modport master (
    output mem_read,
    output mem_addr,
    input  mem_waitrequest,
    input  mem_readdatavalid
  );

  modport slave (
    input  mem_read,
    input  mem_addr,
    output mem_waitrequest,
    output mem_readdatavalid
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Control sequencer for a bank of ROWS MAC lanes computing C = A*b: fetches A rows and b,
// steers each returned word into its lane register, clears the MACs, then runs COLS MAC steps.
module mac_seq_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  result_valid,
  mac_seq_ctrl_if.master        mem,
  output logic [ROWS:0]         load,
  output logic                  shift_en,
  output logic                  mac_clr,
  output logic                  mac_en
);
  localparam int NWORDS = ROWS + 1;
  localparam int FC_W   = $clog2(ROWS + 2);
  localparam int SC_W   = $clog2(COLS + 1);
  localparam logic [FC_W-1:0] WORDS_C   = FC_W'(NWORDS);
  localparam logic [SC_W-1:0] LAST_STEP = SC_W'(COLS - 1);

  // Worst-case dot product must fit the 3*DATA_WIDTH MAC accumulator.
  localparam logic [63:0] ELEM_MAX = (64'd1 << DATA_WIDTH) - 64'd1;
  localparam logic [63:0] MAC_MAX  = 64'(COLS) * ELEM_MAX * ELEM_MAX;

  if (ROWS < 1 || ROWS > 16 || COLS < 1 || COLS > 16 ||
      MAC_MAX >= (64'd1 << (3 * DATA_WIDTH))) begin : g_param_check
    $error("mac_seq_ctrl: ROWS/COLS out of range or MAC accumulator too narrow");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [FC_W-1:0]       issue_q, issue_d;
  logic [FC_W-1:0]       resp_q, resp_d;
  logic [SC_W-1:0]       step_q, step_d;
  logic                  rv_q, rv_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      issue_q <= '0;
      resp_q  <= '0;
      step_q  <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      resp_q  <= resp_d;
      step_q  <= step_d;
      rv_q    <= rv_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    issue_d      = issue_q;
    resp_d       = resp_q;
    step_d       = step_q;
    rv_d         = rv_q;
    busy         = 1'b0;
    done         = 1'b0;
    mac_clr      = 1'b0;
    mac_en       = 1'b0;
    shift_en     = 1'b0;
    load         = '0;
    mem.mem_read = 1'b0;
    mem.mem_addr = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          issue_d = '0;
          resp_d  = '0;
          step_d  = '0;
          rv_d    = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy    = 1'b1;
        mac_clr = 1'b1;
        state_d = S_FILL;
      end
      S_FILL: begin
        busy = 1'b1;
        // Requests and responses run independently; only the response count ends the fill.
        if (issue_q != WORDS_C) begin
          mem.mem_read = 1'b1;
          mem.mem_addr = base_q + ADDR_WIDTH'(issue_q);
          if (!mem.mem_waitrequest) issue_d = issue_q + FC_W'(1);
        end
        if (mem.mem_readdatavalid) begin
          load   = NWORDS'(1) << resp_q;
          resp_d = resp_q + FC_W'(1);
          if (resp_d == WORDS_C) state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        busy     = 1'b1;
        mac_en   = 1'b1;
        shift_en = 1'b1;
        if (step_q == LAST_STEP) begin
          rv_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          step_d = step_q + SC_W'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result_valid = rv_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Randomized bench for mac_seq_ctrl: memory responder, lane/MAC datapath stand-in and a
// timeline model of the job phases derived from start time and response arrivals.
module tb_mac_seq_ctrl;
  localparam int DW     = 8;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int AW     = 32;
  localparam int NW     = ROWS + 1;
  localparam int WORD_W = COLS * DW;

  logic              clk, rst, start;
  logic [AW-1:0]     base_addr;
  logic              busy, done, result_valid, shift_en, mac_clr, mac_en;
  logic [ROWS:0]     load;
  logic [WORD_W-1:0] rdata;

  mac_seq_ctrl_if #(.ADDR_WIDTH(AW)) mif ();

  mac_seq_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .result_valid(result_valid),
    .mem(mif), .load(load), .shift_en(shift_en), .mac_clr(mac_clr), .mac_en(mac_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
  } rsp_t;

  logic [WORD_W-1:0] memory [logic [AW-1:0]];
  rsp_t              rq[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  bit rst_lvl = 1'b1, start_req = 1'b0, stray_en = 1'b0, rand_start_en = 1'b0;
  int wr_mode = 0, lat_mode = 0, last_due = 0;
  logic [AW-1:0] base_drv = '0;

  // job timeline model
  bit job_on = 1'b0, rv_m = 1'b0;
  int S = 0, R = -1, acc_cnt = 0, rsp_cnt = 0;
  logic [AW-1:0] m_base = '0;

  // observations of the current job
  int clr_cyc, rd_first, rd_last, ld_first, ld_last, en_first, en_cnt, done_dut, ld_cnt;
  int done_cnt = 0, busy_rise = 0;
  bit busy_prev = 1'b0, first_addr_set;
  logic [AW-1:0] first_addr, addr_s6;

  logic [WORD_W-1:0] lane [NW];
  longint            acc  [ROWS];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] mem_rd(input logic [AW-1:0] a);
    if (memory.exists(a)) return memory[a];
    return '0;
  endfunction

  function automatic longint exp_mac(input logic [AW-1:0] b, input int r);
    logic [WORD_W-1:0] arow, bvec;
    longint s;
    arow = mem_rd(b + AW'(r));
    bvec = mem_rd(b + AW'(ROWS));
    s = 0;
    for (int k = 0; k < COLS; k++)
      s += longint'(arow[k*DW +: DW]) * longint'(bvec[k*DW +: DW]);
    return s;
  endfunction

  task automatic clear_log();
    clr_cyc = -1; rd_first = -1; rd_last = -1; ld_first = -1; ld_last = -1;
    en_first = -1; en_cnt = 0; done_dut = -1; ld_cnt = 0; first_addr_set = 1'b0;
    first_addr = '0; addr_s6 = '0;
  endtask

  // mode 0: random, 1: row i = i+1 and b = 2, 2: all elements 255
  task automatic fill_job(input logic [AW-1:0] b, input int mode);
    logic [WORD_W-1:0] w;
    for (int r = 0; r <= ROWS; r++) begin
      for (int k = 0; k < COLS; k++) begin
        case (mode)
          1:       w[k*DW +: DW] = (r == ROWS) ? DW'(2) : DW'(r + 1);
          2:       w[k*DW +: DW] = '1;
          default: w[k*DW +: DW] = DW'($urandom);
        endcase
      end
      memory[b + AW'(r)] = w;
    end
  endtask

  task automatic check_cycle();
    int c, lat, due;
    bit idle_now, e_clr, e_fill, e_comp, e_done, e_read;
    logic [AW-1:0] e_addr;
    logic [ROWS:0] e_load;
    c = cyc;
    busy_rise += (busy && !busy_prev) ? 1 : 0;
    busy_prev = busy;
    if (rst) begin
      job_on = 1'b0; rv_m = 1'b0; clear_log();
      chk("rst_busy", busy, 0);        chk("rst_done", done, 0);
      chk("rst_rv", result_valid, 0);  chk("rst_mem_read", mif.mem_read, 0);
      chk("rst_mem_addr", mif.mem_addr, 0); chk("rst_load", load, 0);
      chk("rst_mac_clr", mac_clr, 0);  chk("rst_mac_en", mac_en, 0);
      chk("rst_shift_en", shift_en, 0);
      return;
    end
    idle_now = !job_on;
    e_clr  = job_on && c == S + 1;
    e_fill = job_on && c >= S + 2 && R < 0;
    e_comp = job_on && R >= 0 && c > R && c <= R + COLS;
    e_done = job_on && R >= 0 && c == R + COLS + 1;
    if (e_done) rv_m = 1'b1;
    e_read = e_fill && acc_cnt < NW;
    e_addr = e_read ? m_base + AW'(acc_cnt) : '0;
    e_load = (e_fill && mif.mem_readdatavalid && rsp_cnt < NW) ? NW'(1) << rsp_cnt : '0;

    chk("busy", busy, e_clr || e_fill || e_comp);
    chk("done", done, e_done);
    chk("result_valid", result_valid, rv_m);
    chk("mac_clr", mac_clr, e_clr);
    chk("mac_en", mac_en, e_comp);
    chk("shift_en", shift_en, e_comp);
    chk("mem_read", mif.mem_read, e_read);
    chk("mem_addr", mif.mem_addr, e_addr);
    chk("load", load, e_load);

    if (mac_clr && clr_cyc < 0) clr_cyc = c;
    if (mif.mem_read) begin
      if (rd_first < 0) rd_first = c;
      rd_last = c;
      if (!first_addr_set) begin first_addr = mif.mem_addr; first_addr_set = 1'b1; end
      if (c == S + 6) addr_s6 = mif.mem_addr;
    end
    if (load != '0) begin
      if (ld_first < 0) ld_first = c;
      ld_last = c;
      ld_cnt++;
    end
    if (mac_en) begin
      if (en_first < 0) en_first = c;
      en_cnt++;
    end
    if (done) begin done_cnt++; done_dut = c; end

    // lane registers and MACs as the datapath would see them at the closing edge
    for (int i = 0; i < NW; i++) if (load[i]) lane[i] = rdata;
    if (mac_clr) for (int r = 0; r < ROWS; r++) acc[r] = 0;
    if (mac_en)
      for (int r = 0; r < ROWS; r++)
        acc[r] += longint'(lane[r][DW-1:0]) * longint'(lane[ROWS][DW-1:0]);
    if (shift_en) for (int i = 0; i < NW; i++) lane[i] = lane[i] >> DW;

    if (e_done) begin
      for (int r = 0; r < ROWS; r++) chk("lane_acc", acc[r], exp_mac(m_base, r));
      job_on = 1'b0;
    end

    if (mif.mem_read && !mif.mem_waitrequest) begin
      lat = lat_mode ? int'($urandom_range(1, 4)) : 2;
      due = c + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq.push_back('{due: due, addr: mif.mem_addr});
    end
    if (e_read && !mif.mem_waitrequest) acc_cnt++;
    if (e_load != '0) begin
      rsp_cnt++;
      if (rsp_cnt == NW) R = c;
    end
    if (idle_now && start) begin
      job_on = 1'b1; S = c; R = -1; acc_cnt = 0; rsp_cnt = 0; m_base = base_addr; rv_m = 1'b0;
      clear_log();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    rst       = rst_lvl;
    start     = start_req || (rand_start_en && job_on && $urandom_range(0, 7) == 0);
    base_addr = base_drv;
    case (wr_mode)
      1:       mif.mem_waitrequest = job_on && cyc >= S + 5 && cyc <= S + 7;
      2:       mif.mem_waitrequest = ($urandom_range(0, 9) < 3);
      default: mif.mem_waitrequest = 1'b0;
    endcase
    if (rq.size() > 0 && rq[0].due == cyc) begin
      mif.mem_readdatavalid = 1'b1;
      rdata = mem_rd(rq[0].addr);
      void'(rq.pop_front());
    end else if (stray_en && !job_on && $urandom_range(0, 3) == 0) begin
      mif.mem_readdatavalid = 1'b1;
      rdata = {$urandom, $urandom};
    end else begin
      mif.mem_readdatavalid = 1'b0;
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_job(input logic [AW-1:0] b);
    base_drv  = b;
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    for (int k = 0; k < 400 && job_on; k++) step();
    chk("job_timeout", job_on, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; rdata = '0;
    mif.mem_waitrequest = 1'b0; mif.mem_readdatavalid = 1'b0;
    clear_log();
    for (int i = 0; i < NW; i++) lane[i] = '0;
    for (int r = 0; r < ROWS; r++) acc[r] = 0;

    repeat (3) step();
    chk("reset_busy_lit", busy, 0);
    chk("reset_addr_lit", mif.mem_addr, 0);
    rst_lvl = 1'b0;
    repeat (2) step();

    // nominal timing from the start cycle
    fill_job(32'h100, 0);
    run_job(32'h100);
    chk("t1_clr_cycle", clr_cyc - S, 1);
    chk("t1_read_first", rd_first - S, 2);
    chk("t1_read_last", rd_last - S, 10);
    chk("t1_load_first", ld_first - S, 4);
    chk("t1_load_last", ld_last - S, 12);
    chk("t1_en_first", en_first - S, 13);
    chk("t1_en_count", en_cnt, COLS);
    chk("t1_done_cycle", done_dut - S, 21);

    // known matrix: lane i = 8 * (i+1) * 2
    fill_job(32'h200, 1);
    run_job(32'h200);
    chk("t2_lane0", acc[0], 16);
    chk("t2_lane7", acc[7], 128);
    repeat (3) step();
    chk("t2_rv_held", result_valid, 1);

    // three-cycle stall on the fourth request
    wr_mode = 1;
    fill_job(32'h300, 0);
    run_job(32'h300);
    wr_mode = 0;
    chk("t3_held_addr", addr_s6, 32'h303);
    chk("t3_read_last", rd_last - S, 13);
    chk("t3_loads", ld_cnt, 9);
    chk("t3_done_cycle", done_dut - S, 24);

    // starts during FILL and in the DONE cycle are ignored
    busy_rise = 0; done_cnt = 0;
    fill_job(32'h400, 0);
    base_drv = 32'h400; start_req = 1'b1; step(); start_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      start_req = (cyc + 1 == S + 5) || (cyc + 1 == S + 21);
      step();
    end
    start_req = 1'b0;
    chk("t4_done_count", done_cnt, 1);
    chk("t4_busy_rises", busy_rise, 1);

    // reset during COMPUTE step 4, then a late response, then a clean job
    fill_job(32'h500, 0);
    base_drv = 32'h500; start_req = 1'b1; step(); start_req = 1'b0;
    for (int k = 0; k < 40 && cyc < S + 16; k++) step();
    rst_lvl = 1'b1;
    step();
    chk("t5_async_mac_en", mac_en, 0);
    chk("t5_async_busy", busy, 0);
    step();
    rst_lvl = 1'b0;
    last_due = cyc + 2;
    rq.push_back('{due: cyc + 2, addr: 32'h500});
    repeat (5) step();
    chk("t5_late_load", ld_cnt, 0);
    fill_job(32'h600, 0);
    run_job(32'h600);
    chk("t5_rejob_done", done_dut - S, 21);

    // full-scale elements, then back-to-back with a new base
    fill_job(32'h700, 2);
    run_job(32'h700);
    chk("t6_lane0_max", acc[0], 520200);
    chk("t6_lane7_max", acc[7], 520200);
    fill_job(32'h8000_0000, 0);
    run_job(32'h8000_0000);
    chk("t6_new_base", first_addr, 32'h8000_0000);

    // randomized jobs: stalls, variable latency, strays, spurious starts, address wrap
    stray_en = 1'b1; rand_start_en = 1'b1; lat_mode = 1;
    for (int j = 0; j < 30; j++) begin
      logic [AW-1:0] b;
      wr_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
      b = (j % 5 == 0) ? 32'hFFFF_FFFB : AW'($urandom);
      fill_job(b, 0);
      repeat ($urandom_range(0, 4)) step();
      run_job(b);
    end
    stray_en = 1'b0; rand_start_en = 1'b0; wr_mode = 0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Control-only sequencer for a bank of ROWS MAC lanes computing C = A·b.
- A is a ROWS×COLS matrix, b is a COLS vector, all elements DATA_WIDTH unsigned.
- Fetches ROWS+1 packed words from a memory-mapped read port (A rows, then b), steers each word into the matching lane shift register, clears the MACs, and pulses En for exactly COLS cycles.
- Signals completion; result capture and data unpacking live in the datapath.

Parameters:
- DATA_WIDTH, 8, element width; one memory word = COLS·DATA_WIDTH bits.
- ROWS, 8, MAC lanes / matrix rows (1..16).
- COLS, 8, elements per row = MAC steps per job (1..16).
- ADDR_WIDTH, 32, word-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  word address of A row 0; row i at base_addr+i, b at base_addr+ROWS. Sampled with start.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at job end.
- result_valid  out  1  high from done until next accepted start.
- mem_read  out  1  read request.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_waitrequest  in  1  request stalled; hold mem_read/mem_addr.
- mem_readdatavalid  in  1  in-order response strobe.
- load  out  ROWS+1  one-hot lane load (bit ROWS = b register), combinational from mem_readdatavalid.
- shift_en  out  1  advance all lane shift registers by one element.
- mac_clr  out  1  to every MAC Clr.
- mac_en  out  1  to every MAC En.

Behaviour:
- Reset: state IDLE; busy, done, result_valid, mem_read, mac_clr, mac_en, shift_en = 0; mem_addr = 0; counters = 0. Reset mid-job aborts immediately. Late responses after reset are ignored (load stays 0 outside FILL).
- FSM: IDLE -> CLEAR -> FILL -> COMPUTE -> DONE -> IDLE.
- IDLE: on start, latch base_addr, clear counters, clear result_valid, go CLEAR.
- CLEAR (1 cycle): mac_clr=1. mac_clr and mac_en are never high together.
- FILL issue side: mem_read=1 with mem_addr = base+issue_cnt. issue_cnt increments on cycles with mem_read & ~mem_waitrequest. mem_read drops after ROWS+1 accepted requests. Requests are pipelined; responses need not wait.
- FILL response side: each mem_readdatavalid asserts load[resp_cnt] in the same cycle, then resp_cnt increments. When resp_cnt reaches ROWS+1, go COMPUTE next cycle.
- COMPUTE: mac_en=1 and shift_en=1 for exactly COLS consecutive cycles, step counter 0..COLS-1. The lane register presents element k during step k; the shift takes effect at the end of the step.
- DONE (1 cycle): done=1, result_valid set, busy=0. Then IDLE.
- busy is high during CLEAR, FILL and COMPUTE.
- Any start outside IDLE is ignored, including start in the DONE cycle.
- Stray mem_readdatavalid outside FILL, or beyond ROWS+1 responses: ignored, load=0.
- Counters are $clog2(ROWS+2) and $clog2(COLS+1) bits wide. mem_addr addition wraps modulo 2^ADDR_WIDTH.
- Max MAC growth is COLS·(2^DW−1)²; this must fit the MAC 3·DW output. This holds for COLS ≤ 256 at DW=8.

Test Plan:
1. Defaults, waitrequest=0, readdatavalid 2 cycles after accept, start at cycle 0 -> mac_clr in cycle 1. mem_addr = base..base+8 in cycles 2–10. load bits 0..8 one-hot in order in cycles 4–12. mac_en/shift_en high in cycles 13–20. done in cycle 21.
2. A row i all = i+1, b all = 2, via memory model -> lane i MAC = 16·(i+1), e.g. lane 7 = 128. result_valid stays high after done.
3. mem_waitrequest high 3 cycles on the 4th request -> mem_addr holds base+3 with mem_read high throughout. No duplicate or skipped address. 9 loads total.
4. start pulsed during FILL and in the DONE cycle -> ignored. Exactly one job; busy never re-asserts.
5. rst asserted mid-COMPUTE (step 4) -> all outputs 0 asynchronously, state IDLE. A pending readdatavalid after release produces no load. A new start runs a full correct job.
6. Max values 255 for all elements -> lane MAC = 8·65025 = 520200, no overflow. Back-to-back jobs with a new base_addr fetch from the new addresses.
